// File: rtl/west_feeder_pkg.sv
// Shared definitions for the west-edge feeder: FSM encoding, instruction codes
// and the counter sizing helper.
package west_feeder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StGap,
    StExec,
    StDrain,
    StDone
  } state_e;

  // Lane instruction codes: bit0 = load weight, bit1 = execute
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // One counter serves all phases, so it must reach col, len (up to 255) and row+col
  function automatic int unsigned cnt_width(input int unsigned n_row, input int unsigned n_col);
    int unsigned m;
    m = 255;
    if (n_col > m) m = n_col;
    if (n_row + n_col > m) m = n_row + n_col;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/west_feeder_skew_line.sv
// Fixed-latency delay line used to skew one array lane; depth 0 is a plain wire.
module skew_line #(
  parameter int unsigned width = 1,
  parameter int unsigned depth = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [width-1:0] i_d,
  output logic [width-1:0] o_q
);

  if (depth == 0) begin : g_wire
    logic w_unused;
    assign w_unused = ^{i_clk, i_reset};
    assign o_q      = i_d;
  end else begin : g_pipe
    logic [width-1:0] r_pipe [depth];

    // Shift register: stage 0 takes the input, last stage drives the output
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        for (int unsigned i = 0; i < depth; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= i_d;
        for (int unsigned i = 1; i < depth; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_q = r_pipe[depth-1];
  end

endmodule

// File: rtl/west_feeder.sv
// West-edge feeder for a systolic array: loads col weight vectors, then streams
// len execute vectors, then drains the array. Lane r sees lane 0 delayed r cycles.
module west_feeder
  import west_feeder_pkg::*;
#(
  parameter int unsigned bw  = 4,
  parameter int unsigned row = 8,
  parameter int unsigned col = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        len,
  input  logic [row*bw-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [row*bw-1:0] out_w,
  output logic [row*2-1:0]  inst_w,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = cnt_width(row, col);
  localparam logic [CntW-1:0] LoadCnt  = CntW'(col);
  localparam logic [CntW-1:0] DrainCnt = CntW'(row + col);

  state_e              r_state;
  logic [CntW-1:0]     r_cnt;
  logic [7:0]          r_len;
  logic [1:0]          r_inst0;
  logic [row*bw-1:0]   r_data0;

  logic                w_xfer;
  logic [CntW-1:0]     w_cnt_inc;
  logic [CntW-1:0]     w_len_ext;

  assign in_ready  = (r_state == StLoad) || (r_state == StExec);
  assign w_xfer    = in_valid && in_ready;
  assign w_cnt_inc = r_cnt + CntW'(1);
  assign w_len_ext = CntW'(r_len);
  assign busy      = (r_state != StIdle);
  assign done      = (r_state == StDone);

  // Job sequencing plus the lane-0 stage register; non-transfer cycles emit bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_len   <= '0;
      r_inst0 <= INST_IDLE;
      r_data0 <= '0;
    end else begin
      r_inst0 <= INST_IDLE;
      r_data0 <= '0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StLoad;
            r_len   <= len;
            r_cnt   <= '0;
          end
        end
        StLoad: begin
          if (w_xfer) begin
            r_inst0 <= INST_LOAD;
            r_data0 <= in_data;
            if (w_cnt_inc == LoadCnt) begin
              r_cnt   <= '0;
              r_state <= StGap;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        StGap: begin
          r_state <= (r_len != 8'd0) ? StExec : StDrain;
        end
        StExec: begin
          if (w_xfer) begin
            r_inst0 <= INST_EXEC;
            r_data0 <= in_data;
            if (w_cnt_inc == w_len_ext) begin
              r_cnt   <= '0;
              r_state <= StDrain;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        StDrain: begin
          if (w_cnt_inc == DrainCnt) begin
            r_cnt   <= '0;
            r_state <= StDone;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Diagonal skew: lane r carries its own data slice and the shared instruction
  for (genvar r = 0; r < row; r++) begin : g_lane
    logic [bw+1:0] w_lane_in;
    logic [bw+1:0] w_lane_out;

    assign w_lane_in = {r_inst0, r_data0[r*bw +: bw]};

    skew_line #(
      .width(bw + 2),
      .depth(r)
    ) u_skew (
      .i_clk  (clk),
      .i_reset(reset),
      .i_d    (w_lane_in),
      .o_q    (w_lane_out)
    );

    assign inst_w[2*r +: 2]  = w_lane_out[bw +: 2];
    assign out_w[r*bw +: bw] = w_lane_out[bw-1:0];
  end

endmodule

// File: tb/tb_west_feeder.sv
// Directed bench for west_feeder: traces lanes 0 and 7 per cycle and checks them
// against hand-computed cycle positions.
module tb_west_feeder;

  localparam int Bw  = 4;
  localparam int Row = 8;
  localparam int Col = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [7:0]          len;
  logic [Row*Bw-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [Row*Bw-1:0]   out_w;
  logic [Row*2-1:0]    inst_w;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_errors = 0;
  int n_done;

  // Per-cycle trace; index c holds outputs just after the (c+1)-th edge of the job
  logic [1:0] l_i0 [128];
  logic [1:0] l_i7 [128];
  logic [3:0] l_d0 [128];
  logic [3:0] l_d7 [128];
  logic       l_done [128];
  logic       l_busy [128];
  logic       l_rdy [128];

  always #5 clk = ~clk;

  west_feeder #(
    .bw (Bw),
    .row(Row),
    .col(Col)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .len     (len),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_w   (out_w),
    .inst_w  (inst_w),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int c);
    @(posedge clk);
    #1;
    if (done) n_done++;
    if (c < 128) begin
      l_i0[c]   = inst_w[1:0];
      l_i7[c]   = inst_w[15:14];
      l_d0[c]   = out_w[3:0];
      l_d7[c]   = out_w[31:28];
      l_done[c] = done;
      l_busy[c] = busy;
      l_rdy[c]  = in_ready;
    end
  endtask

  function automatic int count_inst(input int lane, input logic [1:0] v, input int n);
    int k;
    k = 0;
    for (int c = 0; c < n; c++) begin
      if (lane == 0) begin
        if (l_i0[c] == v) k++;
      end else begin
        if (l_i7[c] == v) k++;
      end
    end
    return k;
  endfunction

  // Runs one job; load vector k carries nibble k in every lane, exec vector j nibble 8+j
  task automatic run_job(input int ln, input int bub_at, input int bub_n, input int start_at,
                         input int abort_at, input int ncyc);
    int   nload;
    int   nexec;
    int   bub_left;
    logic xfer;
    logic restarted;
    nload     = 0;
    nexec     = 0;
    bub_left  = 0;
    n_done    = 0;
    restarted = 1'b0;
    for (int c = 0; c < 128; c++) begin
      l_i0[c] = '0; l_i7[c] = '0; l_d0[c] = '0; l_d7[c] = '0;
      l_done[c] = 1'b0; l_busy[c] = 1'b0; l_rdy[c] = 1'b0;
    end
    start = 1'b1;
    len   = ln[7:0];
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) start = 1'b0;
      if (start_at > 0 && nexec == start_at && !restarted) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      if (nload < Col) in_data = {Row{4'(nload + 1)}};
      else             in_data = {Row{4'(nexec + 9)}};
      in_valid = (bub_left == 0);
      if (bub_left > 0) bub_left--;
      xfer = in_valid && in_ready;
      step(c);
      if (xfer) begin
        if (nload < Col) begin
          nload++;
          if (nload == bub_at) bub_left = bub_n;
        end else begin
          nexec++;
        end
      end
      if (abort_at > 0 && nexec == abort_at) begin
        check("abort_pre_busy", {31'd0, busy}, 32'd1);
        check("abort_pre_inst0", {30'd0, inst_w[1:0]}, 32'd2);
        #2 reset = 1'b1;
        #1;
        check("abort_out_w", out_w, 32'd0);
        check("abort_inst_w", {16'd0, inst_w}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        return;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    len      = '0;
    in_data  = '0;
    in_valid = 1'b0;
    #12;
    check("rst_out_w", out_w, 32'd0);
    check("rst_inst_w", {16'd0, inst_w}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    step(200);

    // Basic job, len=2, no bubbles
    run_job(2, 0, 0, 0, 0, 32);
    check("a_idle0", {30'd0, l_i0[0]}, 32'd0);
    check("a_busy0", {31'd0, l_busy[0]}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("a_l0_load_inst%0d", i), {30'd0, l_i0[i]}, 32'd1);
      check($sformatf("a_l0_load_data%0d", i), {28'd0, l_d0[i]}, 32'(i));
      check($sformatf("a_l7_load_inst%0d", i), {30'd0, l_i7[i+7]}, 32'd1);
      check($sformatf("a_l7_load_data%0d", i), {28'd0, l_d7[i+7]}, 32'(i));
    end
    check("a_l0_gap", {30'd0, l_i0[9]}, 32'd0);
    check("a_l7_gap", {30'd0, l_i7[16]}, 32'd0);
    check("a_rdy_load", {31'd0, l_rdy[7]}, 32'd1);
    check("a_rdy_gap", {31'd0, l_rdy[8]}, 32'd0);
    check("a_rdy_exec", {31'd0, l_rdy[9]}, 32'd1);
    check("a_l0_exec1", {30'd0, l_i0[10]}, 32'd2);
    check("a_l0_exec1_d", {28'd0, l_d0[10]}, 32'h9);
    check("a_l0_exec2", {30'd0, l_i0[11]}, 32'd2);
    check("a_l0_exec2_d", {28'd0, l_d0[11]}, 32'hA);
    check("a_l0_drain", {30'd0, l_i0[12]}, 32'd0);
    check("a_l7_exec1", {30'd0, l_i7[17]}, 32'd2);
    check("a_l7_exec2", {30'd0, l_i7[18]}, 32'd2);
    check("a_l7_drain", {30'd0, l_i7[19]}, 32'd0);
    check("a_done_early", {31'd0, l_done[26]}, 32'd0);
    check("a_done", {31'd0, l_done[27]}, 32'd1);
    check("a_busy_after", {31'd0, l_busy[28]}, 32'd0);
    check("a_done_count", 32'(n_done), 32'd1);

    // Three-cycle valid gap after the 4th load transfer
    run_job(1, 4, 3, 0, 0, 40);
    check("b_l0_load4", {30'd0, l_i0[4]}, 32'd1);
    check("b_bubble1", {30'd0, l_i0[5]}, 32'd0);
    check("b_bubble2", {30'd0, l_i0[6]}, 32'd0);
    check("b_bubble3", {30'd0, l_i0[7]}, 32'd0);
    check("b_bubble_d", {28'd0, l_d0[6]}, 32'd0);
    check("b_l0_load5", {30'd0, l_i0[8]}, 32'd1);
    check("b_l0_load5_d", {28'd0, l_d0[8]}, 32'd5);
    check("b_l0_load8_d", {28'd0, l_d0[11]}, 32'd8);
    check("b_load_count", 32'(count_inst(0, 2'b01, 40)), 32'd8);
    check("b_exec_count", 32'(count_inst(0, 2'b10, 40)), 32'd1);
    check("b_l7_load_count", 32'(count_inst(7, 2'b01, 40)), 32'd8);
    check("b_done_count", 32'(n_done), 32'd1);

    // len=0: straight from GAP to DRAIN
    run_job(0, 0, 0, 0, 0, 32);
    check("c_l0_exec_none", 32'(count_inst(0, 2'b10, 32)), 32'd0);
    check("c_l7_exec_none", 32'(count_inst(7, 2'b10, 32)), 32'd0);
    check("c_l0_loads", 32'(count_inst(0, 2'b01, 32)), 32'd8);
    check("c_l7_loads", 32'(count_inst(7, 2'b01, 32)), 32'd8);
    check("c_rdy_gap", {31'd0, l_rdy[8]}, 32'd0);
    check("c_rdy_drain", {31'd0, l_rdy[9]}, 32'd0);
    check("c_done_early", {31'd0, l_done[24]}, 32'd0);
    check("c_done", {31'd0, l_done[25]}, 32'd1);
    check("c_busy_after", {31'd0, l_busy[26]}, 32'd0);
    check("c_done_count", 32'(n_done), 32'd1);

    // Abort in EXEC after 1 of 4 vectors, then a fresh full job
    run_job(4, 0, 0, 0, 1, 40);
    check("d_no_done", 32'(n_done), 32'd0);
    step(200);
    check("d_idle_busy", {31'd0, busy}, 32'd0);
    check("d_idle_inst", {16'd0, inst_w}, 32'd0);
    run_job(2, 0, 0, 0, 0, 32);
    check("d_loads", 32'(count_inst(0, 2'b01, 32)), 32'd8);
    check("d_execs", 32'(count_inst(0, 2'b10, 32)), 32'd2);
    check("d_l0_load1_d", {28'd0, l_d0[1]}, 32'd1);
    check("d_done", {31'd0, l_done[27]}, 32'd1);
    check("d_done_count", 32'(n_done), 32'd1);

    // start pulsed during EXEC is ignored
    run_job(4, 0, 0, 2, 0, 60);
    check("e_done", {31'd0, l_done[29]}, 32'd1);
    check("e_done_count", 32'(n_done), 32'd1);
    check("e_loads", 32'(count_inst(0, 2'b01, 60)), 32'd8);
    check("e_execs", 32'(count_inst(0, 2'b10, 60)), 32'd4);
    check("e_busy_end", {31'd0, l_busy[59]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
